// File: rtl/median_sched_if.sv
// Handshake and median-core bus for median_sched: requester side (REQ/WIN/ACK/RES/ERR/BUSY)
// and core side (M_DSI/M_DI/M_nRST/M_DO/M_DSO).
interface median_sched_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]         REQ;
  logic [N_REQ*9*WIDTH-1:0] WIN;
  logic [N_REQ-1:0]         ACK;
  logic [WIDTH-1:0]         RES;
  logic                     ERR;
  logic                     BUSY;
  logic                     M_DSI;
  logic [WIDTH-1:0]         M_DI;
  logic                     M_nRST;
  logic [WIDTH-1:0]         M_DO;
  logic                     M_DSO;

  modport master (
    output REQ, WIN, M_DO, M_DSO,
    input  ACK, RES, ERR, BUSY, M_DSI, M_DI, M_nRST
  );

  modport slave (
    input  REQ, WIN, M_DO, M_DSO,
    output ACK, RES, ERR, BUSY, M_DSI, M_DI, M_nRST
  );
endinterface

// File: rtl/median_sched.sv
// Round-robin scheduler that feeds one requester's 3x3 window at a time into a shared median core.
// Define MEDIAN_SCHED_TIMEOUT_EN to add a WAIT timeout with a 2-cycle core reset (RECOVER).
module median_sched #(
  parameter int WIDTH       = 8,
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          CLK,
  input  logic          RST,
  median_sched_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
  localparam logic [2:0] RECOVER = 3'd4;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt_reg;
  logic          err_reg;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
`endif

  logic [2:0]       state_reg;
  logic [3:0]       cnt_reg;
  logic [IW-1:0]    last_grant_reg;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] pix_buf [9];

  // Walk from farthest to nearest so the requester closest after last_grant wins.
  always_comb begin
    pick = last_grant_reg;
    idx  = last_grant_reg;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant_reg) + k) % N_REQ);
      if (bus.REQ[idx]) pick = idx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= IW'(N_REQ - 1);
      res_reg        <= '0;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
      wait_cnt_reg   <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.REQ) begin
            last_grant_reg <= pick;
            cnt_reg        <= '0;
            state_reg      <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_reg == 4'd8) begin
            cnt_reg   <= '0;
            state_reg <= WAIT;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        WAIT: begin
          if (bus.M_DSO) begin
            res_reg   <= bus.M_DO;
            state_reg <= DONE;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
            err_reg   <= 1'b0;
          end else if (wait_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
            cnt_reg   <= '0;
            state_reg <= RECOVER;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
`endif
          end
        end
`ifdef MEDIAN_SCHED_TIMEOUT_EN
        RECOVER: begin
          if (cnt_reg == 4'd1) begin
            cnt_reg   <= '0;
            res_reg   <= '0;
            err_reg   <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
`endif
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Snapshot on the grant edge so later WIN changes cannot reach the core.
  always_ff @(posedge CLK) begin
    if (state_reg == IDLE && |bus.REQ) begin
      for (int k = 0; k < 9; k++) begin
        pix_buf[k] <= bus.WIN[(int'(pick) * 9 + k) * WIDTH +: WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
    assign bus.ACK[gi] = (state_reg == DONE) && (last_grant_reg == IW'(gi));
  end

  assign bus.RES   = res_reg;
  assign bus.BUSY  = (state_reg != IDLE);
  assign bus.M_DSI = (state_reg == LOAD);
  assign bus.M_DI  = (state_reg == LOAD) ? pix_buf[cnt_reg] : '0;

`ifdef MEDIAN_SCHED_TIMEOUT_EN
  assign bus.ERR    = err_reg;
  assign bus.M_nRST = ~RST & (state_reg != RECOVER);
`else
  assign bus.ERR    = 1'b0;
  assign bus.M_nRST = ~RST;
`endif
endmodule

// File: tb/tb_median_sched.sv
// Scoreboard bench for median_sched: expected medians are queued as windows are presented
// and matched against RES when ACK appears; a behavioural median core answers the DUT.
module tb_median_sched;
  localparam int WIDTH       = 8;
  localparam int N_REQ       = 4;
  localparam int TIMEOUT_CYC = 64;

  typedef struct {
    int         r;
    logic [7:0] m;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  median_sched_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  median_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  bit   core_hold   = 1'b0;
  bit   spurious_en = 1'b1;

  function automatic logic [7:0] median9(input logic [7:0] p [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = p;
    for (int a = 0; a < 9; a++)
      for (int b = 0; b < 8 - a; b++)
        if (s[b] > s[b+1]) begin
          t = s[b]; s[b] = s[b+1]; s[b+1] = t;
        end
    return s[4];
  endfunction

  task automatic put_window(input int r, input logic [7:0] p [9]);
    exp_t e;
    for (int k = 0; k < 9; k++) bus.WIN[(r*9+k)*8 +: 8] = p[k];
    e.r = r;
    e.m = median9(p);
    sb.push_back(e);
  endtask

  task automatic put_random(input int r);
    logic [7:0] p [9];
    for (int k = 0; k < 9; k++) p[k] = 8'($urandom_range(0, 255));
    put_window(r, p);
  endtask

  task automatic pop_exp(input int r, output logic [7:0] m, output bit found);
    found = 1'b0;
    m     = 8'h00;
    for (int i = 0; i < sb.size(); i++) begin
      if (!found && sb[i].r == r) begin
        m     = sb[i].m;
        found = 1'b1;
        sb.delete(i);
        break;
      end
    end
  endtask

  function automatic int ack_index(input logic [N_REQ-1:0] a);
    int r;
    r = -1;
    for (int i = 0; i < N_REQ; i++) if (a[i]) r = i;
    return r;
  endfunction

  // Behavioural median core: collects 9 pixels, answers after 1..4 cycles, resets on M_nRST=0.
  initial begin : core
    logic [7:0] cbuf [9];
    int         cn;
    int         cd;
    logic [7:0] cmed;
    cn = 0; cd = -1; cmed = 8'h00;
    bus.M_DSO = 1'b0;
    bus.M_DO  = 8'hA5;
    forever begin
      @(negedge clk);
      bus.M_DSO = 1'b0;
      bus.M_DO  = 8'hA5;
      if (bus.M_nRST !== 1'b1) begin
        cn = 0; cd = -1;
      end else if (bus.M_DSI === 1'b1) begin
        cbuf[cn] = bus.M_DI;
        cn++;
        if (cn == 9) begin
          cmed = median9(cbuf);
          cd   = int'($urandom_range(1, 4)) - 1;
          cn   = 0;
        end else if (spurious_en && $urandom_range(0, 7) == 0) begin
          bus.M_DSO = 1'b1;
          bus.M_DO  = 8'h3C;
        end
      end else if (cd >= 0 && !core_hold) begin
        if (cd == 0) begin
          bus.M_DSO = 1'b1;
          bus.M_DO  = cmed;
        end
        cd--;
      end
    end
  end

  task automatic test_reset();
    bus.REQ = '0;
    bus.WIN = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.ACK, bus.RES, bus.ERR, bus.BUSY, bus.M_DSI, bus.M_DI, bus.M_nRST} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ACK=%b RES=%h ERR=%b BUSY=%b DSI=%b DI=%h nRST=%b, want all 0",
               bus.ACK, bus.RES, bus.ERR, bus.BUSY, bus.M_DSI, bus.M_DI, bus.M_nRST);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.M_nRST, bus.BUSY} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: nRST=%b BUSY=%b, want 1 0", bus.M_nRST, bus.BUSY);
    end
    $display("reset: checked");
  endtask

  task automatic test_contention();
    int         order [5];
    int         t;
    logic [3:0] rr;
    logic [7:0] e;
    bit         f;
    order = '{0, 1, 2, 3, 0};
    @(negedge clk);
    for (int r = 0; r < N_REQ; r++) put_random(r);
    bus.REQ = 4'b1111;
    rr = '0;
    t  = 0;
    for (int c = 0; c < 400 && t < 5; c++) begin
      @(negedge clk);
      for (int r = 0; r < N_REQ; r++) if (rr[r]) begin put_random(r); bus.REQ[r] = 1'b1; end
      rr = '0;
      if (bus.ACK != '0) begin
        pop_exp(order[t], e, f);
        n_vec++;
        if (bus.ACK !== 4'(1 << order[t]) || bus.RES !== e || !f) begin
          n_err++;
          $display("FAIL contention_%0d: ACK=%b RES=%h, want ACK=%b RES=%h", t, bus.ACK, bus.RES,
                   4'(1 << order[t]), e);
        end
        $display("contention: ack %b res %h", bus.ACK, bus.RES);
        rr      = bus.ACK;
        bus.REQ = bus.REQ & ~bus.ACK;
        t++;
      end
    end
    bus.REQ = '0;
    n_vec++;
    if (t != 5) begin
      n_err++;
      $display("FAIL contention_count: got %0d ACKs, want 5", t);
    end
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] p [9];
    logic [7:0] e;
    bit         f;
    bit         got;
    p = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    @(negedge clk);
    put_window(0, p);
    bus.REQ = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.M_DSI, bus.M_DI} !== {1'b1, p[k]}) begin
        n_err++;
        $display("FAIL single_load_%0d: DSI=%b DI=%h, want 1 %h", k, bus.M_DSI, bus.M_DI, p[k]);
      end
    end
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (bus.ACK != '0) begin
        got = 1'b1;
        pop_exp(0, e, f);
        n_vec++;
        if ({bus.ACK, bus.RES, bus.ERR} !== {4'b0001, 8'd5, 1'b0} || e !== 8'd5) begin
          n_err++;
          $display("FAIL single_result: ACK=%b RES=%0d ERR=%b, want 0001 5 0", bus.ACK, bus.RES, bus.ERR);
        end
        $display("single: ack %b res %0d err %b", bus.ACK, bus.RES, bus.ERR);
        bus.REQ = '0;
      end
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL single_ack: no ACK within 64 cycles, want one"); end
    @(negedge clk);
    n_vec++;
    if ({bus.ACK, bus.BUSY, bus.M_DSI, bus.M_DI} !== '0) begin
      n_err++;
      $display("FAIL single_idle: ACK=%b BUSY=%b DSI=%b DI=%h, want all 0", bus.ACK, bus.BUSY, bus.M_DSI, bus.M_DI);
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] p [9];
    logic [7:0] e;
    bit         f;
    bit         got;
    for (int k = 0; k < 9; k++) p[k] = 8'(10 * (k + 1));
    @(negedge clk);
    put_window(2, p);
    bus.REQ = 4'b0100;
    @(negedge clk);
    for (int k = 0; k < 9; k++) bus.WIN[(2*9+k)*8 +: 8] = 8'hFF;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (bus.ACK != '0) begin
        got = 1'b1;
        pop_exp(2, e, f);
        n_vec++;
        if ({bus.ACK, bus.RES} !== {4'b0100, 8'd50}) begin
          n_err++;
          $display("FAIL snapshot_result: ACK=%b RES=%0d, want 0100 50", bus.ACK, bus.RES);
        end
        $display("snapshot: ack %b res %0d", bus.ACK, bus.RES);
        bus.REQ = '0;
      end
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL snapshot_ack: no ACK within 64 cycles, want one"); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] e;
    bit         f;
    bit         got;
    bit         acked;
    int         dsi;
    @(negedge clk);
    put_random(0);
    bus.REQ = 4'b0001;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.ACK, bus.RES, bus.ERR, bus.BUSY, bus.M_DSI, bus.M_DI, bus.M_nRST} !== '0) begin
      n_err++;
      $display("FAIL midload_reset: ACK=%b RES=%h ERR=%b BUSY=%b DSI=%b DI=%h nRST=%b, want all 0",
               bus.ACK, bus.RES, bus.ERR, bus.BUSY, bus.M_DSI, bus.M_DI, bus.M_nRST);
    end
    acked = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.ACK != '0) acked = 1'b1;
    end
    #2 rst = 1'b0;
    n_vec++;
    if (acked) begin n_err++; $display("FAIL midload_noack: ACK seen during reset, want none"); end
    dsi = 0;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (bus.M_DSI === 1'b1) dsi++;
      if (bus.ACK != '0) begin
        got = 1'b1;
        pop_exp(0, e, f);
        n_vec++;
        if ({bus.ACK, bus.RES, bus.ERR} !== {4'b0001, e, 1'b0} || !f) begin
          n_err++;
          $display("FAIL midload_result: ACK=%b RES=%h ERR=%b, want 0001 %h 0", bus.ACK, bus.RES, bus.ERR, e);
        end
        $display("midload: ack %b res %h after %0d pixels", bus.ACK, bus.RES, dsi);
        bus.REQ = '0;
      end
    end
    n_vec++;
    if (!got || dsi != 9) begin
      n_err++;
      $display("FAIL midload_reload: ack=%b pixels=%0d, want ack 1 pixels 9", got, dsi);
    end
    @(negedge clk);
  endtask

`ifdef MEDIAN_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] e;
    bit         f;
    bit         got;
    int         wait_cyc;
    int         rec;
    core_hold   = 1'b1;
    spurious_en = 1'b0;
    @(negedge clk);
    put_random(1);
    bus.REQ  = 4'b0010;
    wait_cyc = 0;
    rec      = 0;
    got      = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.ACK != '0) begin
        got = 1'b1;
        pop_exp(1, e, f);
        n_vec++;
        if ({bus.ACK, bus.RES, bus.ERR} !== {4'b0010, 8'h00, 1'b1}) begin
          n_err++;
          $display("FAIL timeout_result: ACK=%b RES=%h ERR=%b, want 0010 00 1", bus.ACK, bus.RES, bus.ERR);
        end
        bus.REQ = '0;
      end else if (bus.M_nRST !== 1'b1) begin
        rec++;
      end else if (bus.BUSY && !bus.M_DSI) begin
        wait_cyc++;
      end
    end
    n_vec++;
    if (!got || wait_cyc != TIMEOUT_CYC || rec != 2) begin
      n_err++;
      $display("FAIL timeout_timing: ack=%b wait=%0d recover=%0d, want 1 %0d 2", got, wait_cyc, rec, TIMEOUT_CYC);
    end
    $display("timeout: wait %0d recover %0d", wait_cyc, rec);
    core_hold = 1'b0;
    @(negedge clk);
    put_random(1);
    bus.REQ = 4'b0010;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (bus.ACK != '0) begin
        got = 1'b1;
        pop_exp(1, e, f);
        n_vec++;
        if ({bus.ACK, bus.RES, bus.ERR} !== {4'b0010, e, 1'b0}) begin
          n_err++;
          $display("FAIL timeout_next: ACK=%b RES=%h ERR=%b, want 0010 %h 0", bus.ACK, bus.RES, bus.ERR, e);
        end
        bus.REQ = '0;
      end
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL timeout_next_ack: no ACK within 64 cycles, want one"); end
    spurious_en = 1'b1;
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    int         done;
    int         idx;
    logic [3:0] just;
    logic [7:0] e;
    bit         f;
    done = 0;
    for (int c = 0; c < 40000 && (done < 1000 || bus.REQ != '0); c++) begin
      @(negedge clk);
      just = '0;
      if (bus.ACK != '0) begin
        n_vec++;
        idx = ack_index(bus.ACK);
        if (!$onehot(bus.ACK) || (bus.ACK & ~bus.REQ) != '0) begin
          n_err++;
          $display("FAIL random_ack: ACK=%b REQ=%b, want one-hot within REQ", bus.ACK, bus.REQ);
        end else begin
          pop_exp(idx, e, f);
          if (!f || {bus.RES, bus.ERR} !== {e, 1'b0}) begin
            n_err++;
            $display("FAIL random_res_%0d: req %0d RES=%h ERR=%b, want %h 0 (queued=%b)", done, idx,
                     bus.RES, bus.ERR, e, f);
          end
        end
        $display("random %0d: ack %b res %h", done, bus.ACK, bus.RES);
        just    = bus.ACK;
        bus.REQ = bus.REQ & ~bus.ACK;
        done++;
      end
      if (done < 1000) begin
        for (int r = 0; r < N_REQ; r++) begin
          if (!bus.REQ[r] && !just[r] && $urandom_range(0, 3) == 0) begin
            put_random(r);
            bus.REQ[r] = 1'b1;
          end
        end
      end
    end
    n_vec++;
    if (done < 1000 || sb.size() != 0 || bus.REQ != '0) begin
      n_err++;
      $display("FAIL random_complete: done=%0d pending=%0d REQ=%b, want >=1000 0 0000", done, sb.size(), bus.REQ);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_snapshot();
    test_reset_mid_load();
`ifdef MEDIAN_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/median_sched.md
MEDIAN_SCHED -- requirements
Module: median_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, maximum WAIT cycles before recovery (TIMEOUT_EN builds only).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port REQ, input, N_REQ bits: request per requester, held high until ACK.
REQ-007 SHALL have port WIN, input, N_REQ*9*WIDTH bits: 3x3 window per requester; pixel k of requester i is WIN[(i*9+k)*WIDTH +: WIDTH].
REQ-008 SHALL have port ACK, output, N_REQ bits: one-hot completion pulse.
REQ-009 SHALL have port RES, output, WIDTH bits: median result, valid while ACK is nonzero.
REQ-010 SHALL have port ERR, output, 1 bit: timeout flag, valid while ACK is nonzero.
REQ-011 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have ports M_DSI (output, 1), M_DI (output, WIDTH), M_nRST (output, 1), M_DO (input, WIDTH) and M_DSO (input, 1), which drive the shared median core.

Function
REQ-013 SHALL implement states IDLE, LOAD, WAIT, DONE and (TIMEOUT_EN builds only) RECOVER.
REQ-014 IDLE: if REQ is nonzero, SHALL grant round-robin, searching from last_grant+1 upward with wrap-around, snapshot the winner's 9 pixels into an internal buffer, and go to LOAD; otherwise SHALL stay in IDLE.
REQ-015 LOAD SHALL last exactly 9 cycles: M_DSI=1 and M_DI=pixel[cnt], with cnt counting 0..8 (pixel 0 first); after cnt=8 SHALL go to WAIT.
REQ-016 Outside LOAD, M_DSI and M_DI SHALL both be 0.
REQ-017 M_DSO SHALL be ignored outside WAIT.
REQ-018 WAIT: on M_DSO=1, SHALL register M_DO into RES, clear ERR, and go to DONE.
REQ-019 DONE SHALL last 1 cycle: ACK[grant]=1, all other ACK bits 0, then go to IDLE.
REQ-020 A requester SHALL drop REQ at the edge where it samples ACK=1; REQ seen high in the following IDLE cycle SHALL count as a new request.
REQ-021 Changes to WIN or REQ of the granted requester after the grant cycle SHALL NOT affect the pixels sent.
REQ-022 Requests arriving while BUSY=1 SHALL wait; no request SHALL be lost while its REQ stays high.
REQ-023 When all requesters request continuously, the grant order SHALL be strictly cyclic (0,1,..,N_REQ-1,0...).
REQ-024 A single requester SHALL be granted again back-to-back.
REQ-025 Minimum transaction time SHALL be 1 (IDLE) + 9 (LOAD) + core latency (WAIT) + 1 (DONE) cycles.
REQ-026 M_nRST SHALL equal ~RST, except that it SHALL be 0 while in RECOVER.

Reset
REQ-027 While RST=1, SHALL immediately force: state=IDLE, cnt=0, last_grant=N_REQ-1 (so requester 0 wins first), ACK=0, RES=0, ERR=0, BUSY=0, M_DSI=0, M_DI=0, M_nRST=0.
REQ-028 RST asserted mid-LOAD or mid-WAIT SHALL abort the transaction without any ACK; the requester SHALL be served again after release if its REQ is still high.

Configuration
REQ-029 With macro MEDIAN_SCHED_TIMEOUT_EN defined, a WAIT counter SHALL run; after TIMEOUT_CYC WAIT cycles without M_DSO, SHALL go to RECOVER.
REQ-030 RECOVER SHALL last 2 cycles with M_nRST=0, then go to DONE with ERR=1 and RES=0.
REQ-031 With the macro undefined, WAIT SHALL last until M_DSO=1 (no limit), the RECOVER state and the counter SHALL be absent, and ERR SHALL be tied to 0.

Verification
REQ-032 Single request: REQ=0001, WIN[0] pixels = 9,1,8,2,7,3,6,4,5 -> M_DI sequence 9..5 over 9 cycles with M_DSI=1, then ACK=0001, RES=5, ERR=0.
REQ-033 Contention: REQ=1111 held, each requester re-raising REQ after its ACK -> ACK order 0001,0010,0100,1000,0001.
REQ-034 Snapshot: change WIN[2] to all 0xFF one cycle after grant to requester 2, with original pixels 10..90 -> RES=50.
REQ-035 Reset mid-LOAD: assert RST at cnt=4 -> outputs 0 immediately, no ACK; after release with REQ still high -> full 9-pixel reload, correct RES.
REQ-036 TIMEOUT_EN build: hold M_DSO=0 -> after 64 WAIT cycles M_nRST=0 for 2 cycles, then ACK with ERR=1, RES=0; next request completes with ERR=0.
REQ-037 Random: 1000 transactions with random REQ and random pixels against a behavioural core -> each RES equals the sorted 5th value and no ACK is missing or duplicated.
